lzw_cam_dict: RTL and testbench
===============================

// Module: lzw_cam_dict
// PURPOSE
//  Parametrised LZW dictionary CAM: successor to the fixed search-only cell array. Adds
//  sequential insert, one-cycle flush, pipelined search with code-offset output, fill tracking.
//  Sits between the LZW compressor FSM (issues {prefix_code,char} keys) and the code emitter.
// PARAMETERS
//  CAM_WIDTH   19    key width; default = 11b prefix code + 8b char
//  NUM_CELL    1792  dictionary entries; default = 2048 codes - 256 literals
//  CODE_BASE   256   code assigned to cell 0; cell i holds code CODE_BASE+i
//  CODE_WIDTH  $clog2(CODE_BASE+NUM_CELL)   derived localparam, not overridable
//  IDX_WIDTH   $clog2(NUM_CELL+1)           derived localparam, not overridable
// PORTS
//  clk          in   1           clock, all state on rising edge
//  rst_n        in   1           async active-low reset
//  clear        in   1           flush: invalidate all cells, count to 0
//  search_req   in   1           start search of search_key this cycle
//  search_key   in   CAM_WIDTH   key to look up
//  insert_req   in   1           write insert_key into next free cell
//  insert_key   in   CAM_WIDTH   key to store
//  rsp_valid    out  1           search result valid (1-cycle pulse)
//  match_found  out  1           qualified by rsp_valid: key present
//  match_code   out  CODE_WIDTH  qualified by rsp_valid&match_found: CODE_BASE+lowest hit idx; else 0
//  insert_ack   out  1           1-cycle pulse: insert accepted
//  insert_code  out  CODE_WIDTH  code assigned by accepted insert; holds until next ack
//  insert_err   out  1           1-cycle pulse: insert dropped because full
//  cam_full     out  1           count == NUM_CELL
//  cam_count    out  IDX_WIDTH   occupied cells
// BEHAVIOUR
//  - Reset (rst_n=0, async): all valid bits 0, count 0; every output 0.
//  - Storage: per cell key reg + valid bit; cells fill strictly in order 0..NUM_CELL-1.
//  - Search pipeline, fixed latency 2: cycle T search_req -> S1 registers per-cell
//    hit vector (valid & key==search_key) -> S2 priority-encodes lowest set index ->
//    rsp_valid at T+2. Back-to-back searches every cycle; no backpressure.
//  - Hit vector sampled against contents at cycle T, before any write in cycle T.
//    Insert at T visible to searches issued T+1 onward.
//  - Multiple hits (duplicate keys, no dedupe on insert): lowest index wins.
//  - Insert: if !cam_full at T, write cell[count], valid=1, count++, insert_ack and
//    insert_code=CODE_BASE+old count at T+1. If full: no write, insert_err at T+1.
//  - cam_full combinational from count register; asserts same cycle count reaches NUM_CELL.
//  - clear: at next edge all valid=0, count=0; overrides same-cycle insert_req (no
//    write, no ack, no err). Kills in-flight searches in S1/S2: no rsp_valid for them.
//    search_req in same cycle as clear is accepted and sees pre-clear contents? No:
//    it is also killed (rsp_valid stays 0).
//  - Simultaneous search_req+insert_req, not full: both proceed; search misses new key.
//  - Async reset mid-operation: pipeline and outputs clear immediately.
// TESTING (bench params CAM_WIDTH=8, NUM_CELL=4, CODE_BASE=256)
//  1 reset, search 8'hFF -> rsp_valid @T+2, match_found=0, match_code=0, cam_count=0
//  2 insert A5,3C,FF -> acks codes 256,257,258; search FF -> match_code=258 @T+2
//  3 fill 4th (11), insert 22 -> insert_err pulse, cam_full=1, count=4, search 22 miss
//  4 insert 7E and search 7E same cycle -> miss; search 7E next cycle -> hit
//  5 insert A5 twice (idx0,idx1), search A5 -> match_code=256 (lowest index)
//  6 searches at T,T+1 then clear at T+1 -> no rsp_valid for either; count=0, full=0

Source files
------------

// File: rtl/lzw_cam_dict_if.sv
// Port bundle between the LZW compressor FSM (master) and the dictionary CAM (slave).
// Requests are single-cycle strobes with no backpressure; responses are 1-cycle pulses.
interface lzw_cam_dict_if #(
  parameter int CAM_WIDTH = 19,
  parameter int NUM_CELL  = 1792,
  parameter int CODE_BASE = 256
);
  localparam int CODE_WIDTH = $clog2(CODE_BASE + NUM_CELL);
  localparam int IDX_WIDTH  = $clog2(NUM_CELL + 1);

  // search_req/insert_req are accepted every cycle they are high: rsp_valid follows a
  // search by exactly 2 cycles, insert_ack/insert_err follow an insert by 1 cycle.
  logic                  clear;
  logic                  search_req;
  logic [CAM_WIDTH-1:0]  search_key;
  logic                  insert_req;
  logic [CAM_WIDTH-1:0]  insert_key;
  logic                  rsp_valid;
  logic                  match_found;
  logic [CODE_WIDTH-1:0] match_code;
  logic                  insert_ack;
  logic [CODE_WIDTH-1:0] insert_code;
  logic                  insert_err;
  logic                  cam_full;
  logic [IDX_WIDTH-1:0]  cam_count;

  modport master (
    output clear, search_req, search_key, insert_req, insert_key,
    input  rsp_valid, match_found, match_code, insert_ack, insert_code,
           insert_err, cam_full, cam_count
  );

  modport slave (
    input  clear, search_req, search_key, insert_req, insert_key,
    output rsp_valid, match_found, match_code, insert_ack, insert_code,
           insert_err, cam_full, cam_count
  );
endinterface

// File: rtl/lzw_cam_dict.sv
// LZW dictionary CAM: in-order insert, one-cycle flush, 2-stage search returning the
// code of the lowest matching cell, and occupancy tracking.
module lzw_cam_dict #(
  parameter int CAM_WIDTH = 19,
  parameter int NUM_CELL  = 1792,
  parameter int CODE_BASE = 256
) (
  input logic           clk,
  input logic           rst_n,
  lzw_cam_dict_if.slave bus
);
  localparam int CODE_WIDTH = $clog2(CODE_BASE + NUM_CELL);
  localparam int IDX_WIDTH  = $clog2(NUM_CELL + 1);
  localparam logic [CODE_WIDTH-1:0] BASE_CODE = CODE_WIDTH'(CODE_BASE);
  localparam logic [IDX_WIDTH-1:0]  FULL_CNT  = IDX_WIDTH'(NUM_CELL);

  logic [CAM_WIDTH-1:0]  key_q [NUM_CELL];
  logic [NUM_CELL-1:0]   valid_q, valid_d;
  logic [IDX_WIDTH-1:0]  count_q, count_d;

  logic [NUM_CELL-1:0]   hit_q, hit_d;
  logic                  s1_valid_q, s1_valid_d;

  logic                  rsp_valid_q, rsp_valid_d;
  logic                  match_found_q, match_found_d;
  logic [CODE_WIDTH-1:0] match_code_q, match_code_d;

  logic                  insert_ack_q, insert_ack_d;
  logic [CODE_WIDTH-1:0] insert_code_q, insert_code_d;
  logic                  insert_err_q, insert_err_d;

  logic                  full;
  logic                  wr_en;
  logic                  enc_found;
  logic [IDX_WIDTH-1:0]  enc_idx;

  assign full  = (count_q == FULL_CNT);
  assign wr_en = bus.insert_req && !bus.clear && !full;

  // Hit vector compares against pre-write contents, so a same-cycle insert is not seen.
  always_comb begin
    hit_d = '0;
    for (int i = 0; i < NUM_CELL; i++) begin
      hit_d[i] = valid_q[i] && (key_q[i] == bus.search_key);
    end
    s1_valid_d = bus.search_req && !bus.clear;
  end

  // Scan downward so the lowest set index is the one left standing.
  always_comb begin
    enc_found = |hit_q;
    enc_idx   = '0;
    for (int i = NUM_CELL - 1; i >= 0; i--) begin
      if (hit_q[i]) enc_idx = IDX_WIDTH'(i);
    end
  end

  always_comb begin
    rsp_valid_d   = s1_valid_q && !bus.clear;
    match_found_d = rsp_valid_d && enc_found;
    match_code_d  = match_found_d ? (BASE_CODE + CODE_WIDTH'(enc_idx)) : '0;
  end

  always_comb begin
    valid_d       = valid_q;
    count_d       = count_q;
    insert_ack_d  = 1'b0;
    insert_err_d  = 1'b0;
    insert_code_d = insert_code_q;
    if (bus.clear) begin
      valid_d = '0;
      count_d = '0;
    end else if (bus.insert_req) begin
      if (!full) begin
        for (int i = 0; i < NUM_CELL; i++) begin
          if (count_q == IDX_WIDTH'(i)) valid_d[i] = 1'b1;
        end
        count_d       = count_q + 1'b1;
        insert_ack_d  = 1'b1;
        insert_code_d = BASE_CODE + CODE_WIDTH'(count_q);
      end else begin
        insert_err_d = 1'b1;
      end
    end
  end

  // Key storage carries no reset: a cell's key is only observable once its valid bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CELL; i++) begin
      if (wr_en && (count_q == IDX_WIDTH'(i))) key_q[i] <= bus.insert_key;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      count_q       <= '0;
      hit_q         <= '0;
      s1_valid_q    <= 1'b0;
      rsp_valid_q   <= 1'b0;
      match_found_q <= 1'b0;
      match_code_q  <= '0;
      insert_ack_q  <= 1'b0;
      insert_code_q <= '0;
      insert_err_q  <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      count_q       <= count_d;
      hit_q         <= hit_d;
      s1_valid_q    <= s1_valid_d;
      rsp_valid_q   <= rsp_valid_d;
      match_found_q <= match_found_d;
      match_code_q  <= match_code_d;
      insert_ack_q  <= insert_ack_d;
      insert_code_q <= insert_code_d;
      insert_err_q  <= insert_err_d;
    end
  end

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.match_found = match_found_q;
  assign bus.match_code  = match_code_q;
  assign bus.insert_ack  = insert_ack_q;
  assign bus.insert_code = insert_code_q;
  assign bus.insert_err  = insert_err_q;
  assign bus.cam_full    = full;
  assign bus.cam_count   = count_q;
endmodule

// File: tb/tb_lzw_cam_dict.sv
// Directed bench for lzw_cam_dict with a 4-entry, 8-bit-key dictionary starting at code 256.
module tb_lzw_cam_dict;
  localparam int CAM_WIDTH = 8;
  localparam int NUM_CELL  = 4;
  localparam int CODE_BASE = 256;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  lzw_cam_dict_if #(.CAM_WIDTH(CAM_WIDTH), .NUM_CELL(NUM_CELL), .CODE_BASE(CODE_BASE)) bus ();

  lzw_cam_dict #(.CAM_WIDTH(CAM_WIDTH), .NUM_CELL(NUM_CELL), .CODE_BASE(CODE_BASE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic f, input logic [31:0] code);
    check({tag, ".rsp_valid"},   32'(bus.rsp_valid),   32'(v));
    check({tag, ".match_found"}, 32'(bus.match_found), 32'(f));
    check({tag, ".match_code"},  32'(bus.match_code),  code);
  endtask

  task automatic idle();
    bus.clear      = 1'b0;
    bus.search_req = 1'b0;
    bus.insert_req = 1'b0;
  endtask

  task automatic do_insert(input logic [7:0] key);
    bus.insert_req = 1'b1;
    bus.insert_key = key;
    tick();
    bus.insert_req = 1'b0;
  endtask

  task automatic do_search(input logic [7:0] key);
    bus.search_req = 1'b1;
    bus.search_key = key;
    tick();
    bus.search_req = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.clear      = 1'b0;
    bus.search_req = 1'b0;
    bus.search_key = '0;
    bus.insert_req = 1'b0;
    bus.insert_key = '0;
    tick();
    tick();
    check_rsp("reset", 1'b0, 1'b0, 0);
    check("reset.ack",   32'(bus.insert_ack),  0);
    check("reset.code",  32'(bus.insert_code), 0);
    check("reset.err",   32'(bus.insert_err),  0);
    check("reset.full",  32'(bus.cam_full),    0);
    check("reset.count", 32'(bus.cam_count),   0);
    rst_n = 1'b1;
    tick();

    // 1: search empty dictionary, latency 2, single-cycle pulse
    do_search(8'hFF);
    check("s1.early", 32'(bus.rsp_valid), 0);
    tick();
    check_rsp("s1", 1'b1, 1'b0, 0);
    check("s1.count", 32'(bus.cam_count), 0);
    tick();
    check("s1.pulse", 32'(bus.rsp_valid), 0);

    // 2: three inserts, then back-to-back searches
    do_insert(8'hA5);
    check("i0.ack", 32'(bus.insert_ack), 1);
    check("i0.code", 32'(bus.insert_code), 256);
    do_insert(8'h3C);
    check("i1.code", 32'(bus.insert_code), 257);
    do_insert(8'hFF);
    check("i2.code", 32'(bus.insert_code), 258);
    check("i2.count", 32'(bus.cam_count), 3);
    tick();
    check("i2.ackpulse", 32'(bus.insert_ack), 0);
    check("i2.codehold", 32'(bus.insert_code), 258);
    do_search(8'hFF);
    do_search(8'hA5);
    check_rsp("s2.ff", 1'b1, 1'b1, 258);
    do_search(8'h3C);
    check_rsp("s2.a5", 1'b1, 1'b1, 256);
    tick();
    check_rsp("s2.3c", 1'b1, 1'b1, 257);
    tick();

    // 3: fill last cell, overflow insert
    check("f.notfull", 32'(bus.cam_full), 0);
    do_insert(8'h11);
    check("f.code", 32'(bus.insert_code), 259);
    check("f.full", 32'(bus.cam_full), 1);
    check("f.count", 32'(bus.cam_count), 4);
    do_insert(8'h22);
    check("f.err", 32'(bus.insert_err), 1);
    check("f.noack", 32'(bus.insert_ack), 0);
    check("f.count2", 32'(bus.cam_count), 4);
    check("f.codehold", 32'(bus.insert_code), 259);
    do_search(8'h22);
    check("f.errpulse", 32'(bus.insert_err), 0);
    do_search(8'h11);
    check_rsp("f.s22", 1'b1, 1'b0, 0);
    tick();
    check_rsp("f.s11", 1'b1, 1'b1, 259);

    // 4: clear, then insert+search same cycle misses, next search hits
    do_clear();
    check("c.count", 32'(bus.cam_count), 0);
    check("c.full", 32'(bus.cam_full), 0);
    bus.insert_req = 1'b1;
    bus.insert_key = 8'h7E;
    bus.search_req = 1'b1;
    bus.search_key = 8'h7E;
    tick();
    bus.insert_req = 1'b0;
    check("ws.ack", 32'(bus.insert_ack), 1);
    check("ws.code", 32'(bus.insert_code), 256);
    tick();
    bus.search_req = 1'b0;
    check_rsp("ws.same", 1'b1, 1'b0, 0);
    tick();
    check_rsp("ws.next", 1'b1, 1'b1, 256);

    // clear beats a same-cycle insert
    bus.clear      = 1'b1;
    bus.insert_req = 1'b1;
    bus.insert_key = 8'h55;
    tick();
    idle();
    check("ci.ack", 32'(bus.insert_ack), 0);
    check("ci.err", 32'(bus.insert_err), 0);
    check("ci.count", 32'(bus.cam_count), 0);

    // 5: duplicate keys, lowest index wins
    do_insert(8'hA5);
    do_insert(8'hA5);
    check("d.code", 32'(bus.insert_code), 257);
    do_search(8'hA5);
    tick();
    check_rsp("d.s", 1'b1, 1'b1, 256);

    // 6: searches at T and T+1, clear at T+1 kills both
    do_search(8'hA5);
    bus.search_req = 1'b1;
    bus.search_key = 8'hA5;
    bus.clear      = 1'b1;
    tick();
    idle();
    check("k.r0", 32'(bus.rsp_valid), 0);
    check("k.count", 32'(bus.cam_count), 0);
    check("k.full", 32'(bus.cam_full), 0);
    tick();
    check("k.r1", 32'(bus.rsp_valid), 0);
    tick();
    check("k.r2", 32'(bus.rsp_valid), 0);
    do_search(8'hA5);
    tick();
    check_rsp("k.after", 1'b1, 1'b0, 0);

    // async reset mid-operation
    do_insert(8'h42);
    do_search(8'h42);
    tick();
    check_rsp("ar.pre", 1'b1, 1'b1, 256);
    #2 rst_n = 1'b0;
    #1;
    check_rsp("ar", 1'b0, 1'b0, 0);
    check("ar.count", 32'(bus.cam_count), 0);
    check("ar.code", 32'(bus.insert_code), 0);
    tick();
    rst_n = 1'b1;
    tick();
    do_search(8'h42);
    tick();
    check_rsp("ar.post", 1'b1, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
